// File: rtl/mmio_hub.sv
// Memory-mapped I/O hub: LED/SEG registers, debounced switches, PS/2 scancode FIFO,
// free-running timer and a level interrupt behind one 8-word register window.
module mmio_hub #(
    parameter int unsigned NUM_SWT   = 8,
    parameter int unsigned NUM_LED   = 8,
    parameter int unsigned KB_DEPTH  = 8,
    parameter int unsigned DB_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic               req_we,
    input  logic [2:0]         req_addr,
    input  logic [31:0]        req_wdata,
    output logic               rsp_valid,
    output logic [31:0]        rsp_rdata,
    input  logic               kb_valid,
    input  logic [7:0]         kb_data,
    input  logic [NUM_SWT-1:0] swt_in,
    output logic [NUM_LED-1:0] led_out,
    output logic [31:0]        seg_num,
    output logic               irq
);

    localparam int unsigned AW  = $clog2(KB_DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned DBW = $clog2(DB_CYCLES);

    localparam logic [2:0] A_KB_DATA = 3'd0;
    localparam logic [2:0] A_KB_STAT = 3'd1;
    localparam logic [2:0] A_SWT     = 3'd2;
    localparam logic [2:0] A_LED     = 3'd3;
    localparam logic [2:0] A_SEG     = 3'd4;
    localparam logic [2:0] A_TIMER   = 3'd5;
    localparam logic [2:0] A_IRQ_EN  = 3'd6;

    logic [7:0]         kb_mem [KB_DEPTH];
    logic [AW-1:0]      kb_wr_ptr;
    logic [AW-1:0]      kb_rd_ptr;
    logic [CW-1:0]      kb_count;
    logic               kb_ovf;

    logic [NUM_SWT-1:0] swt_meta;
    logic [NUM_SWT-1:0] swt_sync;
    logic [NUM_SWT-1:0] swt_prev;
    logic [NUM_SWT-1:0] swt_db;
    logic [DBW-1:0]     db_cnt;

    logic [NUM_LED-1:0] led_q;
    logic [31:0]        seg_q;
    logic [31:0]        timer;
    logic [1:0]         irq_en;

    logic               rd_req_c;
    logic               wr_req_c;
    logic               kb_empty_c;
    logic               kb_full_c;
    logic               kb_pop_c;
    logic               kb_push_c;
    logic               kb_ovf_set_c;
    logic               kb_ovf_clr_c;
    logic               db_tick_c;
    logic [NUM_SWT-1:0] db_match_c;
    logic [31:0]        rd_data_c;

    assign rd_req_c     = req_valid & ~req_we;
    assign wr_req_c     = req_valid & req_we;
    assign kb_empty_c   = (kb_count == '0);
    assign kb_full_c    = (kb_count == CW'(KB_DEPTH));
    assign kb_pop_c     = rd_req_c & (req_addr == A_KB_DATA) & ~kb_empty_c;
    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign kb_push_c    = kb_valid & (~kb_full_c | kb_pop_c);
    assign kb_ovf_set_c = kb_valid & kb_full_c & ~kb_pop_c;
    assign kb_ovf_clr_c = wr_req_c & (req_addr == A_KB_STAT) & req_wdata[2];
    assign db_tick_c    = (db_cnt == DBW'(DB_CYCLES - 1));
    assign db_match_c   = ~(swt_sync ^ swt_prev);

    // Read mux sees pre-edge state, so same-cycle writes/pushes are not reflected.
    always_comb begin
        rd_data_c = '0;
        case (req_addr)
            A_KB_DATA: if (!kb_empty_c) rd_data_c = {23'b0, 1'b1, kb_mem[kb_rd_ptr]};
            A_KB_STAT: rd_data_c = {16'b0, 8'(kb_count), 5'b0, kb_ovf, kb_full_c, ~kb_empty_c};
            A_SWT:     rd_data_c = 32'(swt_db);
            A_LED:     rd_data_c = 32'(led_q);
            A_SEG:     rd_data_c = seg_q;
            A_TIMER:   rd_data_c = timer;
            A_IRQ_EN:  rd_data_c = {30'b0, irq_en};
            default:   rd_data_c = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (kb_push_c) kb_mem[kb_wr_ptr] <= kb_data;
    end

    // FIFO pointers, occupancy and sticky overflow (set beats clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            kb_wr_ptr <= '0;
            kb_rd_ptr <= '0;
            kb_count  <= '0;
            kb_ovf    <= 1'b0;
        end else begin
            if (kb_push_c) kb_wr_ptr <= kb_wr_ptr + AW'(1);
            if (kb_pop_c)  kb_rd_ptr <= kb_rd_ptr + AW'(1);
            case ({kb_push_c, kb_pop_c})
                2'b10:   kb_count <= kb_count + CW'(1);
                2'b01:   kb_count <= kb_count - CW'(1);
                default: kb_count <= kb_count;
            endcase
            if (kb_ovf_set_c)      kb_ovf <= 1'b1;
            else if (kb_ovf_clr_c) kb_ovf <= 1'b0;
        end
    end

    // Switch synchroniser plus tick-sampled debounce: accept a bit on two agreeing ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            swt_meta <= '0;
            swt_sync <= '0;
            swt_prev <= '0;
            swt_db   <= '0;
            db_cnt   <= '0;
        end else begin
            swt_meta <= swt_in;
            swt_sync <= swt_meta;
            db_cnt   <= db_tick_c ? '0 : db_cnt + DBW'(1);
            if (db_tick_c) begin
                swt_prev <= swt_sync;
                swt_db   <= (swt_db & ~db_match_c) | (swt_sync & db_match_c);
            end
        end
    end

    // Writable registers, timer, response and interrupt.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q     <= '0;
            seg_q     <= '0;
            timer     <= '0;
            irq_en    <= '0;
            irq       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (wr_req_c && req_addr == A_LED)    led_q  <= req_wdata[NUM_LED-1:0];
            if (wr_req_c && req_addr == A_SEG)    seg_q  <= req_wdata;
            if (wr_req_c && req_addr == A_IRQ_EN) irq_en <= req_wdata[1:0];
            if (wr_req_c && req_addr == A_TIMER)  timer  <= req_wdata;
            else                                  timer  <= timer + 32'd1;
            irq       <= (irq_en[0] & ~kb_empty_c) | (irq_en[1] & kb_ovf);
            rsp_valid <= req_valid;
            rsp_rdata <= rd_req_c ? rd_data_c : '0;
        end
    end

    assign led_out = led_q;
    assign seg_num = seg_q;

endmodule
